// File: rtl/fir_xifu_ctrl.sv
// Instruction-lifecycle controller for the FIR XIFU pipeline: per-ID issue/commit/kill/retire
// tracking, commit/kill vectors for EX, LSU request gating and pipeline stall/flush generation.
module fir_xifu_ctrl #(
    parameter int unsigned NUM_ID = 4,
    parameter int unsigned ID_W   = $clog2(NUM_ID)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              issue_valid_i,
    input  logic              issue_accept_i,
    input  logic [ID_W-1:0]   issue_id_i,
    output logic              issue_ready_o,
    input  logic              commit_valid_i,
    input  logic [ID_W-1:0]   commit_id_i,
    input  logic              commit_kill_i,
    input  logic              ex_valid_i,
    input  logic [ID_W-1:0]   ex_id_i,
    input  logic              ex_is_load_i,
    input  logic              ex_is_store_i,
    input  logic              mem_ready_i,
    input  logic              mem_result_valid_i,
    input  logic              retire_valid_i,
    input  logic [ID_W-1:0]   retire_id_i,
    input  logic              wb_ready_i,
    output logic [NUM_ID-1:0] commit_o,
    output logic [NUM_ID-1:0] kill_o,
    output logic              mem_allow_o,
    output logic              pipe_ready_o,
    output logic              clear_o,
    output logic [ID_W:0]     outstanding_o,
    output logic              err_o
);
    localparam int unsigned CNT_W = ID_W + 1;

    typedef enum logic [1:0] {
        FREE      = 2'd0,
        ISSUED    = 2'd1,
        COMMITTED = 2'd2,
        KILLED    = 2'd3
    } id_state_e;

    id_state_e         state_q [NUM_ID];
    id_state_e         state_d [NUM_ID];
    logic              load_pending_q;
    logic              issue_fire;
    logic [NUM_ID-1:0] issue_hit;
    logic [NUM_ID-1:0] commit_hit;
    logic [NUM_ID-1:0] retire_hit;
    logic              err_evt;
    logic [CNT_W-1:0]  busy_cnt;
    logic              memop;
    logic              killed_ex;
    logic              stall;
    logic              load_hs;

    assign issue_ready_o = (state_q[issue_id_i] == FREE);
    assign issue_fire    = issue_valid_i & issue_accept_i & issue_ready_o;

    // Per-ID event decode plus the same-cycle commit/kill bypass vectors
    always_comb begin
        issue_hit  = '0;
        commit_hit = '0;
        retire_hit = '0;
        commit_o   = '0;
        kill_o     = '0;
        for (int unsigned i = 0; i < NUM_ID; i++) begin
            issue_hit[i]  = issue_fire && (issue_id_i == ID_W'(i));
            commit_hit[i] = commit_valid_i && (commit_id_i == ID_W'(i));
            retire_hit[i] = retire_valid_i && (retire_id_i == ID_W'(i));
            commit_o[i]   = (state_q[i] == COMMITTED) || (commit_hit[i] && !commit_kill_i);
            kill_o[i]     = (state_q[i] == KILLED) || (commit_hit[i] && commit_kill_i);
        end
    end

    // Next-state per ID; illegal events raise err_evt and leave the state alone
    always_comb begin
        err_evt = 1'b0;
        for (int unsigned i = 0; i < NUM_ID; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                FREE: begin
                    if (issue_hit[i]) begin
                        if (!commit_hit[i]) begin
                            state_d[i] = ISSUED;
                        end else if (commit_kill_i) begin
                            state_d[i] = KILLED;
                        end else begin
                            state_d[i] = COMMITTED;
                        end
                    end else if (commit_hit[i]) begin
                        err_evt = 1'b1;
                    end
                end
                ISSUED: begin
                    if (commit_hit[i]) begin
                        if (commit_kill_i) begin
                            state_d[i] = KILLED;
                        end else begin
                            state_d[i] = COMMITTED;
                        end
                    end
                end
                COMMITTED: begin
                    if (commit_hit[i]) begin
                        err_evt = 1'b1;
                    end
                    if (retire_hit[i]) begin
                        state_d[i] = FREE;
                    end
                end
                KILLED: begin
                    state_d[i] = FREE;
                    if (commit_hit[i]) begin
                        err_evt = 1'b1;
                    end
                end
            endcase
            if (retire_hit[i] && (state_q[i] != COMMITTED)) begin
                err_evt = 1'b1;
            end
        end
    end

    // Occupancy of the next state so the registered count tracks the ID states exactly
    always_comb begin
        busy_cnt = '0;
        for (int unsigned i = 0; i < NUM_ID; i++) begin
            busy_cnt = busy_cnt + CNT_W'(state_d[i] != FREE);
        end
    end

    assign memop        = ex_is_load_i | ex_is_store_i;
    assign killed_ex    = kill_o[ex_id_i];
    assign mem_allow_o  = ex_valid_i & memop & ~killed_ex & ~load_pending_q
                        & (ex_is_load_i | commit_o[ex_id_i]);
    assign stall        = ex_valid_i & ~killed_ex & memop & ~(mem_allow_o & mem_ready_i);
    assign pipe_ready_o = wb_ready_i & ~stall;
    assign clear_o      = ex_valid_i & killed_ex;
    assign load_hs      = ex_valid_i & ex_is_load_i & mem_allow_o & mem_ready_i & pipe_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_ID; i++) begin
                state_q[i] <= FREE;
            end
            load_pending_q <= 1'b0;
            outstanding_o  <= '0;
            err_o          <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_ID; i++) begin
                state_q[i] <= state_d[i];
            end
            load_pending_q <= load_hs | (load_pending_q & ~mem_result_valid_i);
            outstanding_o  <= busy_cnt;
            err_o          <= err_o | err_evt;
        end
    end

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Bench for fir_xifu_ctrl: directed lifecycle scenarios plus random traffic against an ID-set model.
module tb_fir_xifu_ctrl;
    localparam int N = 4;

    logic       clk;
    logic       rst_ni;
    logic       issue_valid, issue_accept, issue_ready;
    logic [1:0] issue_id;
    logic       commit_valid, commit_kill;
    logic [1:0] commit_id;
    logic       ex_valid, ex_is_load, ex_is_store;
    logic [1:0] ex_id;
    logic       mem_ready, mem_result_valid;
    logic       retire_valid;
    logic [1:0] retire_id;
    logic       wb_ready;
    logic [3:0] commit_vec, kill_vec;
    logic       mem_allow, pipe_ready, clear;
    logic [2:0] outstanding;
    logic       err;

    int total = 0;
    int bad   = 0;

    // Model: an ID is busy until freed; busy IDs may carry a committed or killed mark
    bit m_busy [N];
    bit m_comm [N];
    bit m_dead [N];
    bit m_ldpend;
    bit m_err;

    logic [3:0] exp_commit, exp_kill;
    logic       exp_ready, exp_allow, exp_pipe, exp_clear;
    int         exp_out;

    fir_xifu_ctrl dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .issue_valid_i     (issue_valid),
        .issue_accept_i    (issue_accept),
        .issue_id_i        (issue_id),
        .issue_ready_o     (issue_ready),
        .commit_valid_i    (commit_valid),
        .commit_id_i       (commit_id),
        .commit_kill_i     (commit_kill),
        .ex_valid_i        (ex_valid),
        .ex_id_i           (ex_id),
        .ex_is_load_i      (ex_is_load),
        .ex_is_store_i     (ex_is_store),
        .mem_ready_i       (mem_ready),
        .mem_result_valid_i(mem_result_valid),
        .retire_valid_i    (retire_valid),
        .retire_id_i       (retire_id),
        .wb_ready_i        (wb_ready),
        .commit_o          (commit_vec),
        .kill_o            (kill_vec),
        .mem_allow_o       (mem_allow),
        .pipe_ready_o      (pipe_ready),
        .clear_o           (clear),
        .outstanding_o     (outstanding),
        .err_o             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_comm[i] = 1'b0;
            m_dead[i] = 1'b0;
        end
        m_ldpend = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_comb();
        int e;
        e = int'(ex_id);
        for (int i = 0; i < N; i++) begin
            exp_commit[i] = m_comm[i] | (commit_valid & ~commit_kill & (int'(commit_id) == i));
            exp_kill[i]   = m_dead[i] | (commit_valid & commit_kill & (int'(commit_id) == i));
        end
        exp_ready = !m_busy[int'(issue_id)];
        exp_allow = ex_valid & (ex_is_load | ex_is_store) & !exp_kill[e] & !m_ldpend
                  & (ex_is_load | exp_commit[e]);
        exp_pipe  = wb_ready & !(ex_valid & !exp_kill[e] & (ex_is_load | ex_is_store)
                  & !(exp_allow & mem_ready));
        exp_clear = ex_valid & exp_kill[e];
        exp_out   = 0;
        for (int i = 0; i < N; i++) exp_out += int'(m_busy[i]);
    endtask

    task automatic model_step();
        bit nb [N];
        bit nc [N];
        bit nd [N];
        bit e, fire, lhs;
        int c, r;
        model_comb();
        e    = 1'b0;
        fire = issue_valid & issue_accept & exp_ready;
        lhs  = ex_valid & ex_is_load & exp_allow & mem_ready & exp_pipe;
        for (int i = 0; i < N; i++) begin
            nb[i] = m_busy[i];
            nc[i] = m_comm[i];
            nd[i] = m_dead[i];
            if (m_dead[i]) begin
                nb[i] = 1'b0;
                nd[i] = 1'b0;
            end
        end
        if (fire) nb[int'(issue_id)] = 1'b1;
        if (commit_valid) begin
            c = int'(commit_id);
            if (m_busy[c] ? (!m_comm[c] && !m_dead[c]) : (fire && int'(issue_id) == c)) begin
                if (commit_kill) nd[c] = 1'b1;
                else             nc[c] = 1'b1;
            end else begin
                e = 1'b1;
            end
        end
        if (retire_valid) begin
            r = int'(retire_id);
            if (m_comm[r]) begin
                nb[r] = 1'b0;
                nc[r] = 1'b0;
            end else begin
                e = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_busy[i] = nb[i];
            m_comm[i] = nc[i];
            m_dead[i] = nd[i];
        end
        m_ldpend = lhs | (m_ldpend & !mem_result_valid);
        m_err    = m_err | e;
    endtask

    task automatic settle();
        @(negedge clk);
        model_comb();
        chk("issue_ready", 32'(issue_ready), 32'(exp_ready));
        chk("commit_o", 32'(commit_vec), 32'(exp_commit));
        chk("kill_o", 32'(kill_vec), 32'(exp_kill));
        chk("mem_allow", 32'(mem_allow), 32'(exp_allow));
        chk("pipe_ready", 32'(pipe_ready), 32'(exp_pipe));
        chk("clear", 32'(clear), 32'(exp_clear));
        chk("outstanding", 32'(outstanding), 32'(exp_out));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_ni) model_reset();
        else         model_step();
        #1;
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic idle();
        issue_valid = 0; issue_accept = 0; issue_id = 0;
        commit_valid = 0; commit_id = 0; commit_kill = 0;
        ex_valid = 0; ex_id = 0; ex_is_load = 0; ex_is_store = 0;
        mem_ready = 0; mem_result_valid = 0;
        retire_valid = 0; retire_id = 0;
        wb_ready = 1;
    endtask

    task automatic do_issue(input int id);
        idle();
        issue_valid = 1; issue_accept = 1; issue_id = 2'(id);
        cycle();
    endtask

    task automatic do_commit(input int id, input bit kill);
        idle();
        commit_valid = 1; commit_id = 2'(id); commit_kill = kill;
        cycle();
    endtask

    task automatic do_retire(input int id);
        idle();
        retire_valid = 1; retire_id = 2'(id);
        cycle();
    endtask

    task automatic rand_inputs();
        bit legal;
        int c, r, k;
        legal        = ($urandom_range(0, 24) != 0);
        issue_valid  = 1'($urandom_range(0, 1));
        issue_accept = ($urandom_range(0, 3) != 0);
        issue_id     = 2'($urandom_range(0, 3));
        c            = int'($urandom_range(0, 3));
        commit_id    = 2'(c);
        commit_kill  = ($urandom_range(0, 3) == 0);
        commit_valid = ($urandom_range(0, 1) == 0);
        if (legal && !((m_busy[c] && !m_comm[c] && !m_dead[c])
                       || (!m_busy[c] && issue_valid && issue_accept && int'(issue_id) == c)))
            commit_valid = 1'b0;
        r            = int'($urandom_range(0, 3));
        retire_id    = 2'(r);
        retire_valid = ($urandom_range(0, 1) == 0);
        if (legal && !m_comm[r]) retire_valid = 1'b0;
        ex_valid     = 1'($urandom_range(0, 1));
        ex_id        = 2'($urandom_range(0, 3));
        k            = int'($urandom_range(0, 2));
        ex_is_load   = (k == 0);
        ex_is_store  = (k == 1);
        mem_ready    = ($urandom_range(0, 3) != 0);
        wb_ready     = ($urandom_range(0, 4) != 0);
        mem_result_valid = m_ldpend && ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        // Reset and idle
        rst_ni = 1'b0;
        idle();
        model_reset();
        cycle();
        cycle();
        rst_ni = 1'b1;
        settle();
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);
        chk("rst_commit_o", 32'(commit_vec), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("idle_pipe_ready_hi", 32'(pipe_ready), 32'd1);
        tick();
        wb_ready = 0;
        settle();
        chk("idle_pipe_ready_lo", 32'(pipe_ready), 32'd0);
        tick();

        // Issue + commit ID 2 with its store in EX in the same cycle
        idle();
        issue_valid = 1; issue_accept = 1; issue_id = 2;
        commit_valid = 1; commit_id = 2;
        ex_valid = 1; ex_id = 2; ex_is_store = 1; mem_ready = 1;
        settle();
        chk("bypass_mem_allow", 32'(mem_allow), 32'd1);
        chk("bypass_pipe_ready", 32'(pipe_ready), 32'd1);
        tick();
        idle();
        settle();
        chk("id2_committed", 32'(commit_vec), 32'h4);
        tick();
        do_retire(2);

        // Store ID 1 waits for its commit
        do_issue(1);
        for (int n = 0; n < 3; n++) begin
            idle();
            ex_valid = 1; ex_id = 1; ex_is_store = 1; mem_ready = 1;
            settle();
            chk("store_wait_allow", 32'(mem_allow), 32'd0);
            chk("store_wait_pipe", 32'(pipe_ready), 32'd0);
            tick();
        end
        commit_valid = 1; commit_id = 1;
        settle();
        chk("store_release_allow", 32'(mem_allow), 32'd1);
        chk("store_release_pipe", 32'(pipe_ready), 32'd1);
        tick();
        do_retire(1);

        // Back-to-back loads: second waits for the first result
        do_issue(0);
        do_issue(3);
        idle();
        ex_valid = 1; ex_id = 0; ex_is_load = 1; mem_ready = 1;
        settle();
        chk("load0_allow", 32'(mem_allow), 32'd1);
        tick();
        ex_id = 3;
        settle();
        chk("load3_blocked", 32'(mem_allow), 32'd0);
        chk("load3_stall", 32'(pipe_ready), 32'd0);
        tick();
        mem_result_valid = 1;
        settle();
        chk("load3_result_cycle", 32'(mem_allow), 32'd0);
        tick();
        mem_result_valid = 0;
        settle();
        chk("load3_go", 32'(mem_allow), 32'd1);
        chk("load3_go_pipe", 32'(pipe_ready), 32'd1);
        tick();
        idle();
        mem_result_valid = 1;
        cycle();
        do_commit(0, 1'b0);
        do_retire(0);

        // Kill ID 3 while in EX
        idle();
        commit_valid = 1; commit_id = 3; commit_kill = 1;
        ex_valid = 1; ex_id = 3; ex_is_load = 1; mem_ready = 1;
        settle();
        chk("kill_clear", 32'(clear), 32'd1);
        chk("kill_mem_allow", 32'(mem_allow), 32'd0);
        tick();
        idle();
        issue_valid = 1; issue_accept = 1; issue_id = 3;
        settle();
        chk("killed_not_ready", 32'(issue_ready), 32'd0);
        tick();
        idle();
        issue_id = 3;
        settle();
        chk("killed_ready_again", 32'(issue_ready), 32'd1);
        tick();

        // Fill all IDs, retire one, then an illegal commit
        for (int i = 0; i < N; i++) do_issue(i);
        for (int i = 0; i < N; i++) begin
            idle();
            issue_id = 2'(i);
            settle();
            chk("full_not_ready", 32'(issue_ready), 32'd0);
            chk("full_outstanding", 32'(outstanding), 32'd4);
            tick();
        end
        do_commit(1, 1'b0);
        do_retire(1);
        settle();
        chk("after_retire_outstanding", 32'(outstanding), 32'd3);
        chk("after_retire_err", 32'(err), 32'd0);
        tick();
        do_commit(1, 1'b0);
        for (int n = 0; n < 3; n++) begin
            idle();
            settle();
            chk("err_sticky", 32'(err), 32'd1);
            tick();
        end

        // Random traffic from a clean reset
        rst_ni = 1'b0;
        idle();
        model_reset();
        cycle();
        rst_ni = 1'b1;
        for (int n = 0; n < 600; n++) begin
            rand_inputs();
            cycle();
        end

        // Asynchronous reset in the middle of traffic
        for (int n = 0; n < 20; n++) begin
            rand_inputs();
            cycle();
        end
        rst_ni = 1'b0;
        idle();
        model_reset();
        settle();
        chk("midrst_issue_ready", 32'(issue_ready), 32'd1);
        chk("midrst_outstanding", 32'(outstanding), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        tick();
        rst_ni = 1'b1;
        ex_valid = 1; ex_id = 0; ex_is_load = 1; mem_ready = 1;
        settle();
        chk("midrst_load_allow", 32'(mem_allow), 32'd1);
        tick();
        idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fir_xifu_ctrl.md
# fir_xifu_ctrl

Instruction-lifecycle controller for the FIR XIFU pipeline. It tracks every X-interface instruction ID from issue through commit or kill to retirement. It produces the per-ID commit/kill vectors consumed by the EX stage and gates EX memory requests. It generates the pipeline ready/stall and clear signals. It sits beside ID/EX/WB and is the only block that sequences the shared LSU path.

## Interface
Parameters:
- NUM_ID, 4: number of tracked instruction IDs (power of two, ≥2).
- ID_W, $clog2(NUM_ID): ID width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- issue_valid_i  in  1  core offers instruction.
- issue_accept_i  in  1  decoder claims it as an XIFU instruction.
- issue_id_i  in  ID_W  ID of the offered instruction.
- issue_ready_o  out  1  ID slot free; issue may complete.
- commit_valid_i  in  1  commit/kill event.
- commit_id_i  in  ID_W  target ID.
- commit_kill_i  in  1  1 = kill, 0 = commit.
- ex_valid_i  in  1  EX holds a valid instruction.
- ex_id_i  in  ID_W  its ID.
- ex_is_load_i, ex_is_store_i  in  1  EX instruction is XFIRLW / XFIRSW.
- mem_ready_i  in  1  LSU accepts request.
- mem_result_valid_i  in  1  load result returned.
- retire_valid_i  in  1  WB finished an instruction.
- retire_id_i  in  ID_W  its ID.
- wb_ready_i  in  1  downstream ready.
- commit_o  out  NUM_ID  effective committed vector.
- kill_o  out  NUM_ID  effective killed vector.
- mem_allow_o  out  1  EX may drive mem_valid.
- pipe_ready_o  out  1  pipeline advance enable.
- clear_o  out  1  flush EX/WB register.
- outstanding_o  out  ID_W+1  number of non-FREE IDs.
- err_o  out  1  sticky protocol-violation flag.

## Operation
- Each ID has a 2-bit state: FREE, ISSUED, COMMITTED, or KILLED.
- Issue handshake: issue_valid_i & issue_accept_i & issue_ready_o moves FREE to ISSUED.
  - If commit_valid_i targets the same ID in that cycle, the ID goes directly to COMMITTED or KILLED.
- Commit event on ISSUED moves to COMMITTED, or to KILLED when commit_kill_i=1.
  - A commit event on a FREE ID that is not being issued in the same cycle sets err_o. The state does not change.
  - A commit event on a COMMITTED or KILLED ID sets err_o. The state does not change.
- retire_valid_i on a COMMITTED ID moves it to FREE. On any other state, err_o is set and the state does not change.
- KILLED returns to FREE unconditionally on the next cycle.
- commit_o[i] = (state[i]==COMMITTED) | (commit_valid_i & !commit_kill_i & commit_id_i==i).
  - This same-cycle bypass lets a store issue to the LSU in the same cycle it is committed.
- kill_o[i] follows the same rule with kill=1 and state KILLED.
- issue_ready_o = (state[issue_id_i]==FREE).
- Load tracking: load_pending is set when a load completes its memory handshake (ex_valid_i & ex_is_load_i & mem_allow_o & mem_ready_i & pipe_ready_o). It clears on mem_result_valid_i. Results for killed loads are still awaited, then discarded.
- Let memop = ex_is_load_i | ex_is_store_i and killed_ex = kill_o[ex_id_i].
- mem_allow_o = ex_valid_i & memop & !killed_ex & !load_pending & (ex_is_load_i | commit_o[ex_id_i]).
- stall = ex_valid_i & !killed_ex & memop & !(mem_allow_o & mem_ready_i).
- pipe_ready_o = wb_ready_i & !stall.
- clear_o = ex_valid_i & killed_ex. The killed instruction never reaches WB and never drives mem_valid.
- outstanding_o is the registered count of non-FREE IDs, in the range 0..NUM_ID.
- err_o is sticky until reset.

## Timing
- Reset values: all IDs FREE, load_pending=0, commit_o=0, kill_o=0, outstanding_o=0, err_o=0.
- Outputs out of reset: issue_ready_o=1, mem_allow_o=0, clear_o=0, pipe_ready_o=wb_ready_i.
- State, load_pending, outstanding_o and err_o update on the clk_i rising edge after their event (1-cycle latency).
- commit_o, kill_o, mem_allow_o, pipe_ready_o and clear_o are combinational (0-cycle) from their inputs.
- An ID freed by retire in cycle N is issuable in cycle N+1, not in cycle N.
- A KILLED ID entered in cycle N is FREE in cycle N+2 at the earliest.
- Reset asserted mid-operation returns all state to FREE immediately. In-flight load results after reset are ignored (load_pending=0).

## Test plan
- Reset, then idle: issue_ready_o=1, commit_o=4'b0000, outstanding_o=0, pipe_ready_o follows wb_ready_i.
- Issue ID 2, commit ID 2 in the same cycle as a store in EX with mem_ready_i=1: mem_allow_o=1 and pipe_ready_o=1 in that cycle; state[2]=COMMITTED on the next cycle.
- Store ID 1 in EX with no commit for 3 cycles: mem_allow_o=0 and pipe_ready_o=0 for 3 cycles. A commit in cycle 4 releases it in that same cycle.
- Load ID 0 handshakes, then load ID 3 enters EX before mem_result_valid_i: the second load stalls until the result cycle +1.
- Kill ID 3 while it sits in EX: clear_o=1 and mem_allow_o=0 that cycle; ID 3 is issuable again 2 cycles later.
- Fill all 4 IDs: outstanding_o=4 and issue_ready_o=0 for every ID. Retire ID 1: outstanding_o=3 one cycle later. A commit to a FREE ID then sets err_o=1 permanently.
